// File: rtl/ex_stage.sv
// Execute stage: logic/shift/arith in one cycle, registered into the EX/MEM boundary.
// Define EX_MUL_EN to build the iterative 32-cycle shift-add multiplier (alusel 4).
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ex_alusel,
    input  logic [4:0]  ex_aluop,
    input  logic [31:0] ex_srcl,
    input  logic [31:0] ex_srcr,
    input  logic [31:0] ex_offset,
    input  logic [2:0]  ex_memop,
    input  logic [4:0]  ex_dest,
    input  logic        ex_writeEnable,
    input  logic        flush,
    output logic        stall_req,
    output logic [31:0] mem_result,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_storeData,
    output logic [2:0]  mem_memop,
    output logic [4:0]  mem_dest,
    output logic        mem_writeEnable
);

    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_ARITH = 3'd3;
    localparam logic [2:0] SEL_MUL   = 3'd4;

    logic [31:0] alu_result;
    logic [31:0] mul_result;
    logic        mul_done;
    logic        wb_en;
    logic [4:0]  shamt;

    assign shamt = ex_srcr[4:0];

    always_comb begin
        alu_result = '0;
        case (ex_alusel)
            SEL_LOGIC: begin
                case (ex_aluop)
                    5'd0:    alu_result = ex_srcl & ex_srcr;
                    5'd1:    alu_result = ex_srcl | ex_srcr;
                    5'd2:    alu_result = ex_srcl ^ ex_srcr;
                    5'd3:    alu_result = ~(ex_srcl | ex_srcr);
                    default: alu_result = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (ex_aluop)
                    5'd0:    alu_result = ex_srcl << shamt;
                    5'd1:    alu_result = ex_srcl >> shamt;
                    5'd2:    alu_result = $unsigned($signed(ex_srcl) >>> shamt);
                    default: alu_result = '0;
                endcase
            end
            SEL_ARITH: begin
                case (ex_aluop)
                    5'd0:    alu_result = ex_srcl + ex_srcr;
                    5'd1:    alu_result = ex_srcl - ex_srcr;
                    5'd2:    alu_result = {31'b0, $signed(ex_srcl) < $signed(ex_srcr)};
                    5'd3:    alu_result = {31'b0, ex_srcl < ex_srcr};
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

`ifdef EX_MUL_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;

    assign stall_req  = (state == ST_BUSY) ||
                        (state == ST_IDLE && ex_alusel == SEL_MUL && !flush);
    assign mul_done   = (state == ST_DONE);
    assign mul_result = acc;
    assign wb_en      = ex_writeEnable;

    // One shift-add step per BUSY cycle; the 32nd step lands on the edge into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ex_alusel == SEL_MUL) begin
                        mcand  <= ex_srcl;
                        mplier <= ex_srcr;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign stall_req  = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
    assign wb_en      = ex_writeEnable && (ex_alusel != SEL_MUL);
`endif

    // A stalled or flushed cycle leaves a bubble in EX/MEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_result      <= '0;
            mem_addr        <= '0;
            mem_storeData   <= '0;
            mem_memop       <= '0;
            mem_dest        <= '0;
            mem_writeEnable <= 1'b0;
        end else if (flush || stall_req) begin
            mem_result      <= '0;
            mem_addr        <= '0;
            mem_storeData   <= '0;
            mem_memop       <= '0;
            mem_dest        <= '0;
            mem_writeEnable <= 1'b0;
        end else begin
            mem_result      <= mul_done ? mul_result : alu_result;
            mem_addr        <= ex_srcl + ex_offset;
            mem_storeData   <= ex_srcr;
            mem_memop       <= ex_memop;
            mem_dest        <= ex_dest;
            mem_writeEnable <= wb_en;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table for single-cycle ops plus
// hand-written sequences for reset, flush and (with EX_MUL_EN) the multiplier.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ex_alusel;
    logic [4:0]  ex_aluop;
    logic [31:0] ex_srcl, ex_srcr, ex_offset;
    logic [2:0]  ex_memop;
    logic [4:0]  ex_dest;
    logic        ex_writeEnable;
    logic        flush;
    logic        stall_req;
    logic [31:0] mem_result, mem_addr, mem_storeData;
    logic [2:0]  mem_memop;
    logic [4:0]  mem_dest;
    logic        mem_writeEnable;

    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .ex_alusel(ex_alusel), .ex_aluop(ex_aluop),
        .ex_srcl(ex_srcl), .ex_srcr(ex_srcr), .ex_offset(ex_offset),
        .ex_memop(ex_memop), .ex_dest(ex_dest), .ex_writeEnable(ex_writeEnable),
        .flush(flush), .stall_req(stall_req),
        .mem_result(mem_result), .mem_addr(mem_addr), .mem_storeData(mem_storeData),
        .mem_memop(mem_memop), .mem_dest(mem_dest), .mem_writeEnable(mem_writeEnable)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic [4:0]  op;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] off;
        logic [2:0]  memop;
        logic [4:0]  dest;
        logic        we;
        logic [31:0] exp_res;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[15];

    task automatic applyStimulus(input logic [2:0] sel, input logic [4:0] op,
                                 input logic [31:0] l, input logic [31:0] r,
                                 input logic [31:0] off, input logic [2:0] memop,
                                 input logic [4:0] dest, input logic we,
                                 input logic fl);
        ex_alusel      = sel;
        ex_aluop       = op;
        ex_srcl        = l;
        ex_srcr        = r;
        ex_offset      = off;
        ex_memop       = memop;
        ex_dest        = dest;
        ex_writeEnable = we;
        flush          = fl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] res,
                               input logic [31:0] addr, input logic [31:0] sd,
                               input logic [2:0] memop, input logic [4:0] dest,
                               input logic we);
        checks++;
        if (mem_result !== res || mem_addr !== addr || mem_storeData !== sd ||
            mem_memop !== memop || mem_dest !== dest || mem_writeEnable !== we) begin
            errors++;
            $display("[TB] FAIL %s: got res=%h addr=%h sd=%h memop=%0d dest=%0d we=%b, expected res=%h addr=%h sd=%h memop=%0d dest=%0d we=%b",
                     name, mem_result, mem_addr, mem_storeData, mem_memop, mem_dest,
                     mem_writeEnable, res, addr, sd, memop, dest, we);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

`ifdef EX_MUL_EN
    // Presents a MUL, counts stalled cycles, then expects the product one edge after DONE.
    task automatic runMul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int n;
        logic bubbles_ok;
        n = 0;
        bubbles_ok = 1'b1;
        applyStimulus(3'd4, 5'd0, a, b, 32'h0, 3'd0, 5'd9, 1'b1, 1'b0);
        #1;
        while (stall_req === 1'b1 && n < 40) begin
            n++;
            @(posedge clk);
            #1;
            if (mem_writeEnable !== 1'b0 || mem_result !== 32'h0 || mem_dest !== 5'd0 ||
                mem_addr !== 32'h0 || mem_memop !== 3'd0 || mem_storeData !== 32'h0)
                bubbles_ok = 1'b0;
        end
        checkValue({name, " stall cycles"}, n, 32'd33);
        checkValue({name, " bubbles"}, {31'b0, bubbles_ok}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput({name, " result"}, exp, a, b, 3'd0, 5'd9, 1'b1);
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{"OR",         3'd1, 5'd1, 32'h0F0F0000, 32'h000000FF, 32'h0, 3'd0, 5'd3,  1'b1, 32'h0F0F00FF, 32'h0F0F0000};
        vecs[1]  = '{"AND",        3'd1, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 3'd0, 5'd4,  1'b1, 32'hF000F000, 32'hF0F0F0F0};
        vecs[2]  = '{"XOR",        3'd1, 5'd2, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0, 3'd0, 5'd5,  1'b1, 32'hF0F00F0F, 32'hFFFF0000};
        vecs[3]  = '{"NOR",        3'd1, 5'd3, 32'h0F0F0000, 32'h000000FF, 32'h0, 3'd0, 5'd6,  1'b0, 32'hF0F0FF00, 32'h0F0F0000};
        vecs[4]  = '{"SLL",        3'd2, 5'd0, 32'h00000001, 32'h00000123, 32'h0, 3'd0, 5'd7,  1'b1, 32'h00000008, 32'h00000001};
        vecs[5]  = '{"SRL",        3'd2, 5'd1, 32'h80000000, 32'h00000004, 32'h0, 3'd0, 5'd8,  1'b1, 32'h08000000, 32'h80000000};
        vecs[6]  = '{"SRA",        3'd2, 5'd2, 32'h80000000, 32'h00000004, 32'h0, 3'd0, 5'd8,  1'b1, 32'hF8000000, 32'h80000000};
        vecs[7]  = '{"ADD wrap",   3'd3, 5'd0, 32'hFFFFFFFF, 32'h00000002, 32'h0, 3'd0, 5'd1,  1'b1, 32'h00000001, 32'hFFFFFFFF};
        vecs[8]  = '{"SUB wrap",   3'd3, 5'd1, 32'h00000000, 32'h00000001, 32'h0, 3'd0, 5'd2,  1'b1, 32'hFFFFFFFF, 32'h00000000};
        vecs[9]  = '{"SLT",        3'd3, 5'd2, 32'hFFFFFFFF, 32'h00000001, 32'h0, 3'd0, 5'd10, 1'b1, 32'h00000001, 32'hFFFFFFFF};
        vecs[10] = '{"SLTU",       3'd3, 5'd3, 32'hFFFFFFFF, 32'h00000001, 32'h0, 3'd0, 5'd11, 1'b1, 32'h00000000, 32'hFFFFFFFF};
        vecs[11] = '{"LOGIC bad",  3'd1, 5'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 3'd2, 5'd12, 1'b1, 32'h00000000, 32'hFFFFFFFF};
        vecs[12] = '{"NOP load",   3'd0, 5'd0, 32'h00000100, 32'h0000ABCD, 32'hFFFFFFFC, 3'd1, 5'd13, 1'b1, 32'h00000000, 32'h000000FC};
        vecs[13] = '{"SEL 5",      3'd5, 5'd0, 32'h12345678, 32'h11111111, 32'h0, 3'd3, 5'd14, 1'b1, 32'h00000000, 32'h12345678};
        vecs[14] = '{"SHIFT bad",  3'd2, 5'd3, 32'h80000000, 32'h00000001, 32'h0, 3'd4, 5'd15, 1'b1, 32'h00000000, 32'h80000000};

        rst = 1'b1;
        applyStimulus(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0, 1'b0);
        #12;
        checkOutput("reset state", 32'h0, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);
        checkValue("reset stall", {31'b0, stall_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].op, vecs[i].l, vecs[i].r, vecs[i].off,
                          vecs[i].memop, vecs[i].dest, vecs[i].we, 1'b0);
            #1;
            checkValue({vecs[i].name, " stall"}, {31'b0, stall_req}, 32'd0);
            @(posedge clk);
            #1;
            checkOutput(vecs[i].name, vecs[i].exp_res, vecs[i].exp_addr, vecs[i].r,
                        vecs[i].memop, vecs[i].dest, vecs[i].we);
        end

        // Flush kills a normal op.
        applyStimulus(3'd3, 5'd0, 32'h5, 32'h6, 32'h10, 3'd2, 5'd3, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("flush bubble", 32'h0, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);

        // Asynchronous reset mid-cycle clears registered outputs immediately.
        applyStimulus(3'd1, 5'd1, 32'h0F0F0000, 32'h000000FF, 32'h0, 3'd1, 5'd3, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("pre-reset OR", 32'h0F0F00FF, 32'h0F0F0000, 32'h000000FF, 3'd1, 5'd3, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async reset", 32'h0, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);
        checkValue("async reset stall", {31'b0, stall_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifdef EX_MUL_EN
        runMul("MUL small", 32'h00012345, 32'h00000010, 32'h00123450);
        runMul("MUL ones",  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);

        // Flush during BUSY cycle 10 abandons the multiply.
        applyStimulus(3'd4, 5'd0, 32'h3, 32'h5, 32'h0, 3'd0, 5'd9, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("MUL flush bubble", 32'h0, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);
        applyStimulus(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'd0, 5'd9, 1'b1, 1'b0);
        #1;
        checkValue("MUL flush idle", {31'b0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("MUL flush no result", 32'h0, 32'h0, 32'h0, 3'd0, 5'd9, 1'b1);

        // Flush on the start cycle suppresses the stall altogether.
        applyStimulus(3'd4, 5'd0, 32'h3, 32'h5, 32'h0, 3'd0, 5'd9, 1'b1, 1'b1);
        #1;
        checkValue("MUL start flushed stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("MUL start flushed bubble", 32'h0, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);
        applyStimulus(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0, 1'b0);
        #1;
        checkValue("MUL start flushed idle", {31'b0, stall_req}, 32'd0);

        // Reset during BUSY aborts the multiply.
        applyStimulus(3'd4, 5'd0, 32'h7, 32'h9, 32'h0, 3'd0, 5'd9, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        applyStimulus(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0, 1'b0);
        #1;
        checkValue("MUL reset abort stall", {31'b0, stall_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("MUL reset abort outputs", 32'h0, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);
`else
        // Without the multiplier, alusel 4 is a NOP that never writes back.
        applyStimulus(3'd4, 5'd0, 32'h00012345, 32'h00000010, 32'h0, 3'd0, 5'd9, 1'b1, 1'b0);
        #1;
        checkValue("MUL disabled stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("MUL disabled nop", 32'h0, 32'h00012345, 32'h00000010, 3'd0, 5'd9, 1'b0);
        checkValue("MUL disabled stall after", {31'b0, stall_req}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
